// File: rtl/psram_arb_pkg.sv
// Shared types and defaults for the two-port PSRAM arbiter.
package psram_arb_pkg;

  localparam int ADDR_W_DEF = 22;
  localparam int T_ACC_DEF  = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_MCU = 1'b1
  } gnt_e;

  // Choose the port to grant: a lone pending port wins outright, and a
  // collision goes to whichever port was not granted last.
  function automatic gnt_e arb_pick(input logic cpu_pend, input logic mcu_pend,
                                    input gnt_e last_grant);
    gnt_e pick;
    if (cpu_pend && mcu_pend) begin
      pick = (last_grant == GNT_CPU) ? GNT_MCU : GNT_CPU;
    end else if (mcu_pend) begin
      pick = GNT_MCU;
    end else begin
      pick = GNT_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/psram_req_port.sv
// Per-port bookkeeping: served flag, pending decode, ACK pulse and read-data
// register. One instance per requester.
module psram_req_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        ack_set_i,
  input  logic        cap_en_i,
  input  logic [15:0] cap_data_i,
  output logic        pending_o,
  output logic        ack_o,
  output logic [15:0] dati_o
);

  logic        served_q, served_d;
  logic        ack_q, ack_d;
  logic [15:0] dati_q, dati_d;

  // Served sets with the ACK and is held only while the request stays high,
  // so a dropped request clears it straight away.
  always_comb begin
    served_d = (served_q | ack_set_i) & req_i;
    ack_d    = ack_set_i;
    if (cap_en_i) begin
      dati_d = cap_data_i;
    end else begin
      dati_d = dati_q;
    end
  end

  // Port state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      served_q <= 1'b0;
      ack_q    <= 1'b0;
      dati_q   <= 16'h0000;
    end else begin
      served_q <= served_d;
      ack_q    <= ack_d;
      dati_q   <= dati_d;
    end
  end

  assign pending_o = req_i & ~served_q;
  assign ack_o     = ack_q;
  assign dati_o    = dati_q;

endmodule

// File: rtl/psram_arbiter.sv
// Two-port (CPU / MCU) arbiter driving an asynchronous PSRAM with fixed
// access timing. All memory strobes are registered and derived from the
// next-state values so they line up exactly with the ACCESS state.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int T_ACC  = T_ACC_DEF   // legal 2..15
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [15:0]       CPU_DATO,
  input  logic [1:0]        CPU_BE,
  output logic [15:0]       CPU_DATI,
  output logic              CPU_ACK,
  input  logic              MCU_REQ,
  input  logic              MCU_WE,
  input  logic [ADDR_W-1:0] MCU_ADDR,
  input  logic [15:0]       MCU_DATO,
  input  logic [1:0]        MCU_BE,
  output logic [15:0]       MCU_DATI,
  output logic              MCU_ACK,
  output logic [ADDR_W-1:0] PSR_A,
  output logic [15:0]       PSR_DO,
  output logic              PSR_DOE,
  input  logic [15:0]       PSR_DI,
  output logic              PSR_CEn,
  output logic              PSR_OEn,
  output logic              PSR_WEn,
  output logic              PSR_UBn,
  output logic              PSR_LBn
);

  localparam logic [3:0] CNT_LOAD = 4'(T_ACC - 1);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       do_q, do_d;
  logic              cen_q, cen_d, oen_q, oen_d, wen_q, wen_d;
  logic              ubn_q, ubn_d, lbn_q, lbn_d, doe_q, doe_d;

  logic cpu_pend_s, mcu_pend_s;
  logic cpu_ack_set_s, mcu_ack_set_s, cpu_cap_s, mcu_cap_s;
  logic acc_s;
  gnt_e pick_s;

  psram_req_port u_cpu_port (
    .clk        (CLK),
    .rst_n      (RSTn),
    .req_i      (CPU_REQ),
    .ack_set_i  (cpu_ack_set_s),
    .cap_en_i   (cpu_cap_s),
    .cap_data_i (PSR_DI),
    .pending_o  (cpu_pend_s),
    .ack_o      (CPU_ACK),
    .dati_o     (CPU_DATI)
  );

  psram_req_port u_mcu_port (
    .clk        (CLK),
    .rst_n      (RSTn),
    .req_i      (MCU_REQ),
    .ack_set_i  (mcu_ack_set_s),
    .cap_en_i   (mcu_cap_s),
    .cap_data_i (PSR_DI),
    .pending_o  (mcu_pend_s),
    .ack_o      (MCU_ACK),
    .dati_o     (MCU_DATI)
  );

  // Next-state logic: arbitration in IDLE, countdown in ACCESS, one RECOVER cycle.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    be_d          = be_q;
    addr_d        = addr_q;
    do_d          = do_q;
    cpu_ack_set_s = 1'b0;
    mcu_ack_set_s = 1'b0;
    cpu_cap_s     = 1'b0;
    mcu_cap_s     = 1'b0;
    pick_s        = arb_pick(cpu_pend_s, mcu_pend_s, last_q);
    case (state_q)
      ST_IDLE: begin
        if (cpu_pend_s || mcu_pend_s) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_LOAD;
          gnt_d   = pick_s;
          last_d  = pick_s;
          if (pick_s == GNT_CPU) begin
            we_d   = CPU_WE;
            be_d   = CPU_BE;
            addr_d = CPU_ADDR;
            do_d   = CPU_DATO;
          end else begin
            we_d   = MCU_WE;
            be_d   = MCU_BE;
            addr_d = MCU_ADDR;
            do_d   = MCU_DATO;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last access cycle: read data is sampled here and ACK fires next.
          state_d = ST_RECOVER;
          if (gnt_q == GNT_CPU) begin
            cpu_ack_set_s = 1'b1;
            cpu_cap_s     = ~we_q;
          end else begin
            mcu_ack_set_s = 1'b1;
            mcu_cap_s     = ~we_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobe decode from next-state values; WEn releases on the final access
  // cycle so write data is still driven for one cycle after the WE edge.
  always_comb begin
    acc_s = (state_d == ST_ACCESS);
    cen_d = ~acc_s;
    oen_d = ~(acc_s & ~we_d);
    wen_d = ~(acc_s & we_d & (cnt_d != 4'd0));
    doe_d = acc_s & we_d;
    ubn_d = ~(acc_s & be_d[1]);
    lbn_d = ~(acc_s & be_d[0]);
  end

  // State, latched request and registered strobes with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_CPU;
      last_q  <= GNT_MCU;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= '0;
      do_q    <= 16'h0000;
      cen_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      ubn_q   <= 1'b1;
      lbn_q   <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      do_q    <= do_d;
      cen_q   <= cen_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      ubn_q   <= ubn_d;
      lbn_q   <= lbn_d;
      doe_q   <= doe_d;
    end
  end

  assign PSR_A   = addr_q;
  assign PSR_DO  = do_q;
  assign PSR_DOE = doe_q;
  assign PSR_CEn = cen_q;
  assign PSR_OEn = oen_q;
  assign PSR_WEn = wen_q;
  assign PSR_UBn = ubn_q;
  assign PSR_LBn = lbn_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: scenario tasks plus an ACK scoreboard.
module tb_psram_arbiter;

  localparam int AW = 22;
  localparam int TA = 6;

  typedef struct packed {
    logic        port;   // 0 = CPU, 1 = MCU
    logic [15:0] dati;
  } ev_t;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          CPU_REQ, CPU_WE, MCU_REQ, MCU_WE;
  logic [AW-1:0] CPU_ADDR, MCU_ADDR, PSR_A;
  logic [15:0]   CPU_DATO, MCU_DATO, CPU_DATI, MCU_DATI, PSR_DO, PSR_DI;
  logic [1:0]    CPU_BE, MCU_BE;
  logic          CPU_ACK, MCU_ACK, PSR_DOE;
  logic          PSR_CEn, PSR_OEn, PSR_WEn, PSR_UBn, PSR_LBn;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor accumulators, cleared per scenario.
  int cyc, cen_n, oen_n, wen_n, doe_n, ubl_n, lbl_n;
  int cpu_ack_n, mcu_ack_n, cpu_ack_cyc, mcu_ack_cyc, first_cen;
  logic [AW-1:0] seen_a;
  logic [15:0]   seen_do;
  logic [15:0]   cpu_m, mcu_m;   // model of each port's DATI register
  ev_t exp_q[$];
  ev_t act_q[$];
  ev_t e, a;

  psram_arbiter #(.ADDR_W(AW), .T_ACC(TA)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DATO(CPU_DATO),
    .CPU_BE(CPU_BE), .CPU_DATI(CPU_DATI), .CPU_ACK(CPU_ACK),
    .MCU_REQ(MCU_REQ), .MCU_WE(MCU_WE), .MCU_ADDR(MCU_ADDR), .MCU_DATO(MCU_DATO),
    .MCU_BE(MCU_BE), .MCU_DATI(MCU_DATI), .MCU_ACK(MCU_ACK),
    .PSR_A(PSR_A), .PSR_DO(PSR_DO), .PSR_DOE(PSR_DOE), .PSR_DI(PSR_DI),
    .PSR_CEn(PSR_CEn), .PSR_OEn(PSR_OEn), .PSR_WEn(PSR_WEn),
    .PSR_UBn(PSR_UBn), .PSR_LBn(PSR_LBn)
  );

  always #5 CLK = ~CLK;

  task automatic clr_mon();
    cyc = 0; cen_n = 0; oen_n = 0; wen_n = 0; doe_n = 0; ubl_n = 0; lbl_n = 0;
    cpu_ack_n = 0; mcu_ack_n = 0; cpu_ack_cyc = 0; mcu_ack_cyc = 0; first_cen = 0;
    seen_a = '0; seen_do = 16'h0000;
  endtask

  // Advance one clock and record what the memory side and ACKs did.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
    if (PSR_CEn === 1'b0) begin
      cen_n++;
      if (first_cen == 0) first_cen = cyc;
      seen_a = PSR_A;
    end
    if (PSR_OEn === 1'b0) oen_n++;
    if (PSR_WEn === 1'b0) wen_n++;
    if (PSR_DOE === 1'b1) begin doe_n++; seen_do = PSR_DO; end
    if (PSR_UBn === 1'b0) ubl_n++;
    if (PSR_LBn === 1'b0) lbl_n++;
    if (CPU_ACK === 1'b1) begin cpu_ack_n++; cpu_ack_cyc = cyc; act_q.push_back({1'b0, CPU_DATI}); end
    if (MCU_ACK === 1'b1) begin mcu_ack_n++; mcu_ack_cyc = cyc; act_q.push_back({1'b1, MCU_DATI}); end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DATO = 16'h0000; CPU_BE = 2'b11;
    MCU_REQ = 1'b0; MCU_WE = 1'b0; MCU_ADDR = '0; MCU_DATO = 16'h0000; MCU_BE = 2'b11;
    PSR_DI = 16'h0000;
    cpu_m = 16'h0000; mcu_m = 16'h0000;
    clr_mon();
    tick(); tick(); tick();
    n_checks++; if ({PSR_CEn, PSR_OEn, PSR_WEn, PSR_UBn, PSR_LBn} !== 5'b11111) begin n_fail++; $display("FAIL reset_strobes got %b want 11111", {PSR_CEn, PSR_OEn, PSR_WEn, PSR_UBn, PSR_LBn}); end
    n_checks++; if (PSR_DOE !== 1'b0) begin n_fail++; $display("FAIL reset_doe got %b want 0", PSR_DOE); end
    n_checks++; if (PSR_A !== '0 || PSR_DO !== 16'h0000) begin n_fail++; $display("FAIL reset_a_do got %h/%h want 0/0", PSR_A, PSR_DO); end
    n_checks++; if (CPU_ACK !== 1'b0 || MCU_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b%b want 00", CPU_ACK, MCU_ACK); end
    n_checks++; if (CPU_DATI !== 16'h0000 || MCU_DATI !== 16'h0000) begin n_fail++; $display("FAIL reset_dati got %h/%h want 0/0", CPU_DATI, MCU_DATI); end
    RSTn = 1'b1;
    tick(); tick();
  endtask

  task automatic test_cpu_read();
    CPU_WE = 1'b0; CPU_ADDR = 22'h000123; CPU_BE = 2'b11; PSR_DI = 16'hA55A;
    CPU_REQ = 1'b1;
    exp_q.push_back({1'b0, 16'hA55A}); cpu_m = 16'hA55A;
    clr_mon();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (CPU_ACK === 1'b1) CPU_REQ = 1'b0;
    end
    n_checks++; if (first_cen !== 1) begin n_fail++; $display("FAIL rd_grant_cycle got %0d want 1", first_cen); end
    n_checks++; if (oen_n !== TA) begin n_fail++; $display("FAIL rd_oen_cycles got %0d want %0d", oen_n, TA); end
    n_checks++; if (wen_n !== 0 || doe_n !== 0) begin n_fail++; $display("FAIL rd_no_write got wen=%0d doe=%0d want 0/0", wen_n, doe_n); end
    n_checks++; if (cpu_ack_cyc !== TA + 1 || cpu_ack_n !== 1) begin n_fail++; $display("FAIL rd_ack got cyc=%0d n=%0d want %0d/1", cpu_ack_cyc, cpu_ack_n, TA + 1); end
    n_checks++; if (seen_a !== 22'h000123) begin n_fail++; $display("FAIL rd_addr got %h want 000123", seen_a); end
    n_checks++; if (CPU_DATI !== 16'hA55A) begin n_fail++; $display("FAIL rd_dati got %h want a55a", CPU_DATI); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL rd_sb missing ack want port=%0d dati=%h", e.port, e.dati); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL rd_sb got port=%0d dati=%h want port=%0d dati=%h", a.port, a.dati, e.port, e.dati); end end
    end
  endtask

  task automatic test_mcu_write();
    MCU_WE = 1'b1; MCU_ADDR = 22'h3FFFFF; MCU_DATO = 16'hBEEF; MCU_BE = 2'b01;
    MCU_REQ = 1'b1;
    exp_q.push_back({1'b1, mcu_m});
    clr_mon();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (MCU_ACK === 1'b1) MCU_REQ = 1'b0;
    end
    n_checks++; if (lbl_n !== TA || ubl_n !== 0) begin n_fail++; $display("FAIL wr_byte_lanes got lb=%0d ub=%0d want %0d/0", lbl_n, ubl_n, TA); end
    n_checks++; if (wen_n !== TA - 1) begin n_fail++; $display("FAIL wr_wen_cycles got %0d want %0d", wen_n, TA - 1); end
    n_checks++; if (doe_n !== TA || oen_n !== 0) begin n_fail++; $display("FAIL wr_doe got doe=%0d oen=%0d want %0d/0", doe_n, oen_n, TA); end
    n_checks++; if (seen_do !== 16'hBEEF || seen_a !== 22'h3FFFFF) begin n_fail++; $display("FAIL wr_data_addr got %h/%h want beef/3fffff", seen_do, seen_a); end
    n_checks++; if (mcu_ack_n !== 1 || cpu_ack_n !== 0) begin n_fail++; $display("FAIL wr_ack_count got mcu=%0d cpu=%0d want 1/0", mcu_ack_n, cpu_ack_n); end
    n_checks++; if (CPU_DATI !== cpu_m) begin n_fail++; $display("FAIL wr_other_dati got %h want %h", CPU_DATI, cpu_m); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL wr_sb missing ack want port=%0d", e.port); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL wr_sb got port=%0d dati=%h want port=%0d dati=%h", a.port, a.dati, e.port, e.dati); end end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] di;
    for (int p = 0; p < 4; p++) begin
      di = 16'h1000 + 16'(p * 16'h0111);
      PSR_DI = di;
      CPU_WE = 1'b0; CPU_ADDR = 22'(p + 16); CPU_BE = 2'b11;
      MCU_WE = 1'b0; MCU_ADDR = 22'(p + 32); MCU_BE = 2'b10;
      CPU_REQ = 1'b1; MCU_REQ = 1'b1;
      exp_q.push_back({1'b0, di}); exp_q.push_back({1'b1, di});
      cpu_m = di; mcu_m = di;
      clr_mon();
      for (int c = 0; c < 20; c++) begin
        tick();
        if (CPU_ACK === 1'b1) CPU_REQ = 1'b0;
        if (MCU_ACK === 1'b1) MCU_REQ = 1'b0;
      end
      n_checks++; if (cpu_ack_n !== 1 || mcu_ack_n !== 1) begin n_fail++; $display("FAIL b2b_acks pair %0d got cpu=%0d mcu=%0d want 1/1", p, cpu_ack_n, mcu_ack_n); end
      n_checks++; if (mcu_ack_cyc - cpu_ack_cyc !== TA + 2) begin n_fail++; $display("FAIL b2b_spacing pair %0d got %0d want %0d", p, mcu_ack_cyc - cpu_ack_cyc, TA + 2); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act_q.size() == 0) begin n_fail++; $display("FAIL b2b_sb missing ack want port=%0d", e.port); end
        else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL b2b_sb got port=%0d dati=%h want port=%0d dati=%h", a.port, a.dati, e.port, e.dati); end end
      end
    end
  endtask

  task automatic test_hold_req();
    CPU_WE = 1'b1; CPU_ADDR = 22'h000055; CPU_DATO = 16'h1234; CPU_BE = 2'b11;
    CPU_REQ = 1'b1;
    exp_q.push_back({1'b0, cpu_m});
    clr_mon();
    for (int c = 0; c < 30; c++) tick();
    CPU_REQ = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_checks++; if (cpu_ack_n !== 1 || cen_n !== TA) begin n_fail++; $display("FAIL hold_single got acks=%0d cen=%0d want 1/%0d", cpu_ack_n, cen_n, TA); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL hold_sb missing ack"); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL hold_sb got port=%0d dati=%h want port=%0d dati=%h", a.port, a.dati, e.port, e.dati); end end
    end
  endtask

  task automatic test_drop_mid();
    CPU_WE = 1'b0; CPU_ADDR = 22'h000777; CPU_BE = 2'b11; PSR_DI = 16'hC3C3;
    CPU_REQ = 1'b1;
    exp_q.push_back({1'b0, 16'hC3C3});
    clr_mon();
    tick(); tick();
    CPU_REQ = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    PSR_DI = 16'h3C3C;
    CPU_REQ = 1'b1;
    exp_q.push_back({1'b0, 16'h3C3C}); cpu_m = 16'h3C3C;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (CPU_ACK === 1'b1) CPU_REQ = 1'b0;
    end
    n_checks++; if (cpu_ack_n !== 2) begin n_fail++; $display("FAIL drop_acks got %0d want 2", cpu_ack_n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL drop_sb missing ack want dati=%h", e.dati); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL drop_sb got port=%0d dati=%h want port=%0d dati=%h", a.port, a.dati, e.port, e.dati); end end
    end
  endtask

  task automatic test_reset_abort();
    MCU_WE = 1'b0; MCU_ADDR = 22'h000ABC; MCU_BE = 2'b11; PSR_DI = 16'hDEAD;
    MCU_REQ = 1'b1;
    clr_mon();
    tick(); tick(); tick();
    RSTn = 1'b0;
    tick();
    n_checks++; if ({PSR_CEn, PSR_OEn, PSR_WEn, PSR_UBn, PSR_LBn} !== 5'b11111) begin n_fail++; $display("FAIL abort_strobes got %b want 11111", {PSR_CEn, PSR_OEn, PSR_WEn, PSR_UBn, PSR_LBn}); end
    MCU_REQ = 1'b0;
    cpu_m = 16'h0000; mcu_m = 16'h0000;
    tick();
    RSTn = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    n_checks++; if (mcu_ack_n !== 0 || cpu_ack_n !== 0) begin n_fail++; $display("FAIL abort_no_ack got mcu=%0d cpu=%0d want 0/0", mcu_ack_n, cpu_ack_n); end
    n_checks++; if (MCU_DATI !== 16'h0000) begin n_fail++; $display("FAIL abort_dati got %h want 0000", MCU_DATI); end
    PSR_DI = 16'h5AA5; MCU_ADDR = 22'h000ABD;
    MCU_REQ = 1'b1;
    exp_q.push_back({1'b1, 16'h5AA5}); mcu_m = 16'h5AA5;
    clr_mon();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (MCU_ACK === 1'b1) MCU_REQ = 1'b0;
    end
    n_checks++; if (mcu_ack_cyc !== TA + 1 || mcu_ack_n !== 1) begin n_fail++; $display("FAIL abort_new_req got cyc=%0d n=%0d want %0d/1", mcu_ack_cyc, mcu_ack_n, TA + 1); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act_q.size() == 0) begin n_fail++; $display("FAIL abort_sb missing ack"); end
      else begin a = act_q.pop_front(); if (a !== e) begin n_fail++; $display("FAIL abort_sb got port=%0d dati=%h want port=%0d dati=%h", a.port, a.dati, e.port, e.dati); end end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_cpu_read();
    test_mcu_write();
    test_back_to_back();
    test_hold_req();
    test_drop_mid();
    test_reset_abort();
    n_checks++; if (act_q.size() !== 0) begin n_fail++; $display("FAIL stray_acks got %0d want 0", act_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 22, PSRAM word-address width.
REQ-002 Parameter T_ACC, default 6, CLK cycles per PSRAM access; legal range 2..15.
REQ-003 CLK  input  1  the only clock; all logic on its rising edge.
REQ-004 RSTn  input  1  synchronous, active-low reset.
REQ-005 CPU_REQ  input  1  console-bus access request (level); already synchronized to CLK.
REQ-006 CPU_WE  input  1  1 = write, 0 = read.
REQ-007 CPU_ADDR  input  ADDR_W  word address.
REQ-008 CPU_DATO  input  16  write data.
REQ-009 CPU_BE  input  2  byte enables; [1] upper, [0] lower.
REQ-010 CPU_DATI  output  16  read data, valid from the CPU_ACK cycle onward.
REQ-011 CPU_ACK  output  1  one-cycle completion pulse.
REQ-012 MCU_REQ, MCU_WE, MCU_ADDR, MCU_DATO, MCU_BE, MCU_DATI, MCU_ACK  same directions, widths and meanings as REQ-005..011, for the MCU/SPI port.
REQ-013 PSR_A  output  ADDR_W  memory address.
REQ-014 PSR_DO  output  16  write data; PSR_DOE  output  1  data-bus drive enable.
REQ-015 PSR_DI  input  16  read data.
REQ-016 PSR_CEn, PSR_OEn, PSR_WEn, PSR_UBn, PSR_LBn  output  1 each  active-low memory strobes.

Function
REQ-017 FSM states: IDLE, ACCESS, RECOVER.
REQ-018 Each port SHALL hold a served flag. The flag sets in the cycle ACK is issued and clears when REQ is low. A port is pending when REQ=1 and served=0.
REQ-019 In IDLE with exactly one port pending, that port SHALL be granted at the next edge.
REQ-020 If both ports are pending, the grant SHALL go to the port not granted last (last_grant register). CPU wins on the first collision after reset.
REQ-021 On grant, the FSM SHALL latch the port's WE/ADDR/DATO/BE internally and enter ACCESS for exactly T_ACC cycles.
REQ-022 During ACCESS the outputs SHALL be: PSR_CEn=0; PSR_A = latched address; PSR_UBn = !BE[1]; PSR_LBn = !BE[0].
REQ-023 Read access: PSR_OEn=0 for all ACCESS cycles, PSR_DOE=0.
REQ-024 Write access: PSR_DOE=1 and PSR_DO = latched data for all ACCESS cycles; PSR_WEn=0 for ACCESS cycles 1..T_ACC-1 only, so data is held for one cycle after WEn rises.
REQ-025 On the last ACCESS cycle, a read SHALL capture PSR_DI into the granted port's DATI register. The other port's DATI SHALL be unchanged.
REQ-026 The granted port's ACK SHALL pulse high for one cycle, the cycle after the last ACCESS cycle, coincident with the RECOVER state.
REQ-027 RECOVER SHALL last 1 cycle with all strobes inactive and PSR_DOE=0, then return to IDLE.
REQ-028 Grant-to-ACK latency SHALL be T_ACC+1 cycles; minimum request-to-request spacing SHALL be T_ACC+2 cycles.
REQ-029 If REQ drops mid-access, the access SHALL complete and ACK SHALL still pulse; served then clears immediately.
REQ-030 A port holding REQ high after ACK SHALL NOT be re-granted until REQ has been low for at least one cycle.
REQ-031 Outside ACCESS, all strobes SHALL be 1, PSR_DOE=0, and PSR_A SHALL hold its last value.

Reset
REQ-032 While RSTn=0 at an edge, the block SHALL force:
- state = IDLE;
- PSR_CEn/OEn/WEn/UBn/LBn = 1, PSR_DOE = 0, PSR_A = 0, PSR_DO = 0;
- both ACKs = 0, both DATI = 0;
- served flags = 0, last_grant = MCU.
REQ-033 Reset asserted during ACCESS SHALL abort the access with no ACK; strobes are inactive from the next edge.

Structure
REQ-034 Package psram_arb_pkg SHALL hold: the state enum; the grant enum (GNT_CPU, GNT_MCU); the default ADDR_W and T_ACC constants.
REQ-035 The per-port served flag, pending logic and DATI register SHALL be one sub-module, psram_req_port, instantiated twice.
REQ-036 Access timing SHALL use one 4-bit down-counter loaded with T_ACC-1 on grant.

Verification
REQ-037 CPU read only (T_ACC=6), ADDR=0x00123, PSR_DI=0xA55A -> OEn low 6 cycles, CPU_ACK 7 cycles after grant, CPU_DATI=0xA55A.
REQ-038 MCU write, ADDR=0x3FFFFF, DATO=0xBEEF, BE=2'b01 -> LBn=0, UBn=1, WEn low 5 cycles, DOE high 6 cycles, single MCU_ACK.
REQ-039 CPU_REQ and MCU_REQ rise on the same cycle after reset -> CPU granted first, MCU granted on the next IDLE; alternation holds over 4 back-to-back pairs.
REQ-040 CPU_REQ held high for 30 cycles -> exactly one CPU access and one CPU_ACK.
REQ-041 RSTn low on ACCESS cycle 3 -> no ACK, all strobes 1 next cycle; a new MCU_REQ after reset is served normally.
